// File: rtl/multicycle_main_fsm_pkg.sv
// Shared control definitions for the multicycle RISC-V control path:
// immediate formats, opcode values, main FSM states and datapath mux
// select / ALU operation encodings.
package multicycle_main_fsm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_JALR,
        S_JALR_LINK,
        S_LUI,
        S_TRAP
    } state_t;

    // result mux
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU source A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    // ALU source B mux
    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALU operation class (resolved further by the external ALU decoder)
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

endpackage

// File: rtl/multicycle_main_fsm_imm_src_decoder.sv
// Immediate format decoder: maps the IR opcode field to the immediate
// extension format. Purely combinational.
//   op_i       - opcode field of IR
//   imm_src_o  - immediate format for the extender
module imm_src_decoder
    import multicycle_main_fsm_pkg::*;
(
    input  logic [6:0] op_i,
    output imm_src_t   imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_STORE:          imm_src_o = IMM_S;
            OP_BRANCH:         imm_src_o = IMM_B;
            OP_JAL:            imm_src_o = IMM_J;
            OP_LUI, OP_AUIPC:  imm_src_o = IMM_U;
            default:           imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives the
// shared-bus datapath selects and enables (Moore outputs).
//   clk_i, rst_i         - clock, synchronous active-high reset
//   op_i                 - opcode field of IR
//   mem_ready_i          - memory completes the current access this cycle
//   mem_req_o/adr_src_o  - memory request and address source
//   ir_write_o, pc_update_o, branch_o, mem_write_o, reg_write_o - enables
//   result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o - datapath selects
//   imm_src_o            - immediate format (combinational from op_i)
//   retire_o             - pulse in the final cycle of each instruction
//   illegal_o            - sticky illegal-opcode trap flag
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter bit EN_JALR       = 1'b1,
    parameter bit EN_AUIPC      = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_update_o,
    output logic       branch_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output imm_src_t   imm_src_o,
    output logic       retire_o,
    output logic       illegal_o
);

    state_t state, state_next;
    logic   ready;

    assign ready = MEM_HANDSHAKE ? mem_ready_i : 1'b1;

    imm_src_decoder u_imm_src_decoder (
        .op_i      (op_i),
        .imm_src_o (imm_src_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= state_next;
    end

    // The whole decode sits under !rst_i so every output reads 0 while reset
    // is held, regardless of the (possibly mid-instruction) current state.
    always_comb begin
        state_next   = state;
        mem_req_o    = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_update_o  = 1'b0;
        branch_o     = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_WDATA;
        alu_op_o     = ALU_ADD;
        retire_o     = 1'b0;
        illegal_o    = 1'b0;
        if (!rst_i) begin
            case (state)
                S_FETCH: begin
                    mem_req_o    = 1'b1;
                    ir_write_o   = ready;
                    pc_update_o  = ready;
                    alu_src_b_o  = SRCB_FOUR;
                    result_src_o = RES_ALU;
                    if (ready) state_next = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a_o = SRCA_OLDPC;
                    alu_src_b_o = SRCB_IMM;
                    case (op_i)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_R:              state_next = S_EXECR;
                        OP_I:              state_next = S_EXECI;
                        OP_BRANCH:         state_next = S_BEQ;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = EN_JALR ? S_JALR : S_TRAP;
                        OP_LUI:            state_next = S_LUI;
                        // OldPC+imm computed here is already the auipc result
                        OP_AUIPC:          state_next = EN_AUIPC ? S_ALUWB : S_TRAP;
                        default:           state_next = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a_o = SRCA_A;
                    alu_src_b_o = SRCB_IMM;
                    state_next  = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_req_o = 1'b1;
                    adr_src_o = 1'b1;
                    if (ready) state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src_o = RES_DATA;
                    reg_write_o  = 1'b1;
                    retire_o     = 1'b1;
                    state_next   = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req_o   = 1'b1;
                    adr_src_o   = 1'b1;
                    mem_write_o = ready;
                    retire_o    = ready;
                    if (ready) state_next = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a_o = SRCA_A;
                    alu_src_b_o = SRCB_WDATA;
                    alu_op_o    = ALU_FUNCT;
                    state_next  = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a_o = SRCA_A;
                    alu_src_b_o = SRCB_IMM;
                    alu_op_o    = ALU_FUNCT;
                    state_next  = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_b_o = SRCB_IMM;
                    alu_op_o    = ALU_PASSB;
                    state_next  = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src_o = RES_ALUOUT;
                    reg_write_o  = 1'b1;
                    retire_o     = 1'b1;
                    state_next   = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a_o  = SRCA_A;
                    alu_src_b_o  = SRCB_WDATA;
                    alu_op_o     = ALU_SUB;
                    result_src_o = RES_ALUOUT;
                    branch_o     = 1'b1;
                    retire_o     = 1'b1;
                    state_next   = S_FETCH;
                end
                S_JAL, S_JALR_LINK: begin
                    alu_src_a_o  = SRCA_OLDPC;
                    alu_src_b_o  = SRCB_FOUR;
                    result_src_o = RES_ALUOUT;
                    pc_update_o  = 1'b1;
                    state_next   = S_ALUWB;
                end
                S_JALR: begin
                    alu_src_a_o = SRCA_A;
                    alu_src_b_o = SRCB_IMM;
                    state_next  = S_JALR_LINK;
                end
                S_TRAP: begin
                    illegal_o  = 1'b1;
                    state_next = S_TRAP;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm. Instance A uses the default
// parameters; instance B disables jalr/auipc and the memory handshake.
module tb_multicycle_main_fsm;
    import multicycle_main_fsm_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
    } ctl_t;

    typedef struct {
        string       tag;
        logic [19:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] op_i = OP_LOAD;
    logic       mem_ready_i = 1'b0;

    logic       a_mem_req, a_adr_src, a_ir_write, a_pc_update, a_branch;
    logic       a_mem_write, a_reg_write, a_retire, a_illegal;
    logic [1:0] a_result_src, a_src_a, a_src_b, a_alu_op;
    imm_src_t   a_imm;
    logic       b_mem_req, b_adr_src, b_ir_write, b_pc_update, b_branch;
    logic       b_mem_write, b_reg_write, b_retire, b_illegal;
    logic [1:0] b_result_src, b_src_a, b_src_b, b_alu_op;
    imm_src_t   b_imm;

    int unsigned checks = 0;
    int unsigned errors = 0;
    sb_t         q[$];
    logic        use_b = 1'b0;
    logic        sel_b = 1'b0;

    always #5 clk = ~clk;

    multicycle_main_fsm dut_a (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(a_mem_req), .adr_src_o(a_adr_src), .ir_write_o(a_ir_write),
        .pc_update_o(a_pc_update), .branch_o(a_branch), .mem_write_o(a_mem_write),
        .reg_write_o(a_reg_write), .result_src_o(a_result_src), .alu_src_a_o(a_src_a),
        .alu_src_b_o(a_src_b), .alu_op_o(a_alu_op), .imm_src_o(a_imm),
        .retire_o(a_retire), .illegal_o(a_illegal)
    );

    multicycle_main_fsm #(
        .EN_JALR(1'b0), .EN_AUIPC(1'b0), .MEM_HANDSHAKE(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(b_mem_req), .adr_src_o(b_adr_src), .ir_write_o(b_ir_write),
        .pc_update_o(b_pc_update), .branch_o(b_branch), .mem_write_o(b_mem_write),
        .reg_write_o(b_reg_write), .result_src_o(b_result_src), .alu_src_a_o(b_src_a),
        .alu_src_b_o(b_src_b), .alu_op_o(b_alu_op), .imm_src_o(b_imm),
        .retire_o(b_retire), .illegal_o(b_illegal)
    );

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control word per state, straight from the state output table.
    function automatic ctl_t exp_ctl(input string st, input logic r);
        ctl_t c;
        c = '0;
        case (st)
            "FETCH":    begin c.mem_req = 1; c.ir_write = r; c.pc_update = r;
                              c.result_src = 2'b10; c.src_b = 2'b10; end
            "DECODE":   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            "MEMADR":   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            "MEMREAD":  begin c.mem_req = 1; c.adr_src = 1; end
            "MEMWB":    begin c.result_src = 2'b01; c.reg_write = 1; c.retire = 1; end
            "MEMWRITE": begin c.mem_req = 1; c.adr_src = 1; c.mem_write = r; c.retire = r; end
            "EXECR":    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
            "EXECI":    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
            "LUI":      begin c.src_b = 2'b01; c.alu_op = 2'b11; end
            "ALUWB":    begin c.reg_write = 1; c.retire = 1; end
            "BEQ":      begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1; c.retire = 1; end
            "JAL", "JALR_LINK":
                        begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1; end
            "JALR":     begin c.src_a = 2'b10; c.src_b = 2'b01; end
            "TRAP":     c.illegal = 1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_for(input logic [6:0] op);
        if (op == 7'b0100011) return 3'd1;                         // IMM_S
        if (op == 7'b1100011) return 3'd2;                         // IMM_B
        if (op == 7'b1101111) return 3'd3;                         // IMM_J
        if (op == 7'b0110111 || op == 7'b0010111) return 3'd4;     // IMM_U
        return 3'd0;                                               // IMM_I
    endfunction

    // One cycle: drive inputs just after the edge and queue the expected word.
    // Instance B ignores ready, so it always sees ready low but expects ready=1.
    task automatic step(input string tag, input logic rst, input logic [6:0] op,
                        input logic rdy, input string st);
        sb_t e;
        @(posedge clk);
        #1;
        sel_b       = use_b;
        rst_i       = rst;
        op_i        = op;
        mem_ready_i = use_b ? 1'b0 : rdy;
        e.tag = tag;
        e.exp = {exp_ctl(rst ? "RST" : st, use_b ? 1'b1 : rdy), imm_for(op)};
        q.push_back(e);
    endtask

    // fw/mw: wait cycles in fetch / memory state; idle: ready level elsewhere.
    task automatic instr(input string nm, input logic [6:0] op, input int unsigned fw,
                         input int unsigned mw, input logic idle);
        for (int unsigned i = 0; i < fw; i++) step({nm, ".fetch_wait"}, 0, op, 0, "FETCH");
        step({nm, ".fetch"}, 0, op, 1, "FETCH");
        step({nm, ".decode"}, 0, op, idle, "DECODE");
        case (op)
            OP_LOAD: begin
                step({nm, ".memadr"}, 0, op, idle, "MEMADR");
                for (int unsigned i = 0; i < mw; i++) step({nm, ".memread_wait"}, 0, op, 0, "MEMREAD");
                step({nm, ".memread"}, 0, op, 1, "MEMREAD");
                step({nm, ".memwb"}, 0, op, idle, "MEMWB");
            end
            OP_STORE: begin
                step({nm, ".memadr"}, 0, op, idle, "MEMADR");
                for (int unsigned i = 0; i < mw; i++) step({nm, ".memwrite_wait"}, 0, op, 0, "MEMWRITE");
                step({nm, ".memwrite"}, 0, op, 1, "MEMWRITE");
            end
            OP_R:      begin step({nm, ".exec"}, 0, op, idle, "EXECR"); step({nm, ".wb"}, 0, op, idle, "ALUWB"); end
            OP_I:      begin step({nm, ".exec"}, 0, op, idle, "EXECI"); step({nm, ".wb"}, 0, op, idle, "ALUWB"); end
            OP_BRANCH: step({nm, ".beq"}, 0, op, idle, "BEQ");
            OP_JAL:    begin step({nm, ".jal"}, 0, op, idle, "JAL"); step({nm, ".wb"}, 0, op, idle, "ALUWB"); end
            OP_LUI:    begin step({nm, ".lui"}, 0, op, idle, "LUI"); step({nm, ".wb"}, 0, op, idle, "ALUWB"); end
            OP_JALR:
                if (!use_b) begin
                    step({nm, ".jalr"}, 0, op, idle, "JALR");
                    step({nm, ".link"}, 0, op, idle, "JALR_LINK");
                    step({nm, ".wb"}, 0, op, idle, "ALUWB");
                end else step({nm, ".trap"}, 0, op, idle, "TRAP");
            OP_AUIPC:  step({nm, ".wb_or_trap"}, 0, op, idle, use_b ? "TRAP" : "ALUWB");
            default:   step({nm, ".trap"}, 0, op, idle, "TRAP");
        endcase
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            sb_t e;
            e = q.pop_front();
            if (sel_b)
                check(e.tag, {b_mem_req, b_adr_src, b_ir_write, b_pc_update, b_branch,
                              b_mem_write, b_reg_write, b_result_src, b_src_a, b_src_b,
                              b_alu_op, b_retire, b_illegal, b_imm}, e.exp);
            else
                check(e.tag, {a_mem_req, a_adr_src, a_ir_write, a_pc_update, a_branch,
                              a_mem_write, a_reg_write, a_result_src, a_src_a, a_src_b,
                              a_alu_op, a_retire, a_illegal, a_imm}, e.exp);
        end
    end

    initial begin
        // instance A: all features enabled, handshake active
        step("reset0", 1, OP_LOAD, 1, "RST");
        step("reset1", 1, OP_LOAD, 1, "RST");
        instr("lw",      OP_LOAD,   0, 0, 1);
        instr("r_fw3",   OP_R,      3, 0, 1);
        instr("sw_mw2",  OP_STORE,  0, 2, 1);
        instr("i_idle0", OP_I,      0, 0, 0);
        instr("beq",     OP_BRANCH, 0, 0, 1);
        instr("auipc",   OP_AUIPC,  0, 0, 1);
        instr("jalr",    OP_JALR,   0, 0, 1);
        instr("jal",     OP_JAL,    0, 0, 0);
        instr("lui",     OP_LUI,    1, 0, 1);
        instr("lw_mw1",  OP_LOAD,   0, 1, 0);
        // reset lands in the writeback cycle of a load
        step("lwrst.fetch",  0, OP_LOAD, 1, "FETCH");
        step("lwrst.decode", 0, OP_LOAD, 1, "DECODE");
        step("lwrst.memadr", 0, OP_LOAD, 1, "MEMADR");
        step("lwrst.memrd",  0, OP_LOAD, 1, "MEMREAD");
        step("lwrst.rst",    1, OP_LOAD, 1, "RST");
        instr("after_rst", OP_BRANCH, 0, 0, 1);
        // illegal opcode: sticky until reset
        instr("ill", 7'b1111111, 0, 0, 1);
        step("ill.sticky0", 0, 7'b1111111, 0, "TRAP");
        step("ill.sticky1", 0, OP_LOAD,    1, "TRAP");
        step("ill.sticky2", 0, OP_STORE,   1, "TRAP");
        step("ill.rst",     1, OP_R,       1, "RST");
        instr("ill_clear", OP_I, 0, 0, 1);

        // instance B: jalr/auipc disabled, ready ignored (driven low)
        use_b = 1'b1;
        step("b.reset", 1, OP_LOAD, 1, "RST");
        instr("b.lw",   OP_LOAD,  0, 0, 0);
        instr("b.sw",   OP_STORE, 0, 0, 0);
        instr("b.auipc", OP_AUIPC, 0, 0, 0);
        step("b.auipc.sticky", 0, OP_AUIPC, 0, "TRAP");
        step("b.rst1", 1, OP_JALR, 0, "RST");
        instr("b.jalr", OP_JALR, 0, 0, 0);
        step("b.jalr.sticky", 0, OP_LUI, 0, "TRAP");
        step("b.rst2", 1, OP_JAL, 0, "RST");
        instr("b.jal",  OP_JAL, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
